// File: rtl/transforms_pkg.sv
// Shared types and packing helpers for the transformer char-memory / line-table
// write path. Field layout matches what the read path decodes.
package transforms_pkg;

  typedef enum logic [1:0] {
    ST_LHS    = 2'd0,
    ST_RHS    = 2'd1,
    ST_COMMIT = 2'd2,
    ST_FULL   = 2'd3
  } state_t;

  // Char-memory address reserved as the out-of-bounds sentinel; never written.
  localparam logic [7:0] OOB_ADDR = 8'hFF;

  // Line-pointer word: {len, start}.
  localparam int PTR_LEN_MSB   = 15;
  localparam int PTR_LEN_LSB   = 8;
  localparam int PTR_START_MSB = 7;
  localparam int PTR_START_LSB = 0;

  function automatic logic [15:0] pack_pair(input logic [7:0] lhs, input logic [7:0] rhs);
    return {lhs, rhs};
  endfunction

  function automatic logic [15:0] pack_ptr(input logic [7:0] len, input logic [7:0] start);
    logic [15:0] ptr;
    ptr = '0;
    ptr[PTR_LEN_MSB:PTR_LEN_LSB]     = len;
    ptr[PTR_START_MSB:PTR_START_LSB] = start;
    return ptr;
  endfunction

endpackage

// File: rtl/transform_loader.sv
// Byte-stream loader: packs (lhs,rhs) ASCII pairs into 16-bit char-memory words
// and emits one {len,start} line-pointer entry per committed line.
module transform_loader
  import transforms_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int LINE_W   = 8,
  parameter int MEM_LAST = 254
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              ptr_we,
  output logic [LINE_W-1:0] ptr_line,
  output logic [15:0]       ptr_data,
  output logic [LINE_W:0]   line_count,
  output logic              full,
  output logic              err,
  output state_t            dbg_state
);

  // Handshake: a byte moves on a rising edge where in_valid & in_ready; in_ready
  // depends only on state (and is held low while reset is asserted), never on in_valid.

  localparam logic [ADDR_W:0]   MEM_LAST_P = (ADDR_W+1)'(MEM_LAST);
  localparam logic [LINE_W-1:0] LINE_LAST  = {LINE_W{1'b1}};

  state_t              r_state;
  logic [ADDR_W:0]     r_wr_ptr;
  logic [ADDR_W-1:0]   r_line_start;
  logic [7:0]          r_line_len;
  logic [LINE_W-1:0]   r_line_idx;
  logic [LINE_W:0]     r_line_count;
  logic [7:0]          r_lhs;
  logic                r_full;
  logic                r_err;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [15:0]         r_mem_din;
  logic                r_ptr_we;
  logic [LINE_W-1:0]   r_ptr_line;
  logic [15:0]         r_ptr_data;

  logic                w_accept_ok;

  assign w_accept_ok = (r_state == ST_LHS) || (r_state == ST_RHS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_LHS;
      r_wr_ptr     <= '0;
      r_line_start <= '0;
      r_line_len   <= '0;
      r_line_idx   <= '0;
      r_line_count <= '0;
      r_lhs        <= '0;
      r_full       <= 1'b0;
      r_err        <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_ptr_we     <= 1'b0;
      r_ptr_line   <= '0;
      r_ptr_data   <= '0;
    end else begin
      r_mem_we <= 1'b0;
      r_ptr_we <= 1'b0;
      if (clear && (r_state != ST_FULL)) begin
        // Restart the pointers; sticky full/err survive.
        r_state      <= ST_LHS;
        r_wr_ptr     <= '0;
        r_line_start <= '0;
        r_line_len   <= '0;
        r_line_idx   <= '0;
        r_line_count <= '0;
        r_lhs        <= '0;
      end else begin
        case (r_state)
          ST_LHS: begin
            if (in_valid) begin
              if (in_last) begin
                r_err   <= 1'b1;
                r_state <= ST_COMMIT;
              end else begin
                r_lhs   <= in_data;
                r_state <= ST_RHS;
              end
            end
          end
          ST_RHS: begin
            if (in_valid) begin
              r_mem_we   <= (r_wr_ptr[ADDR_W-1:0] != OOB_ADDR[ADDR_W-1:0]);
              r_mem_addr <= r_wr_ptr[ADDR_W-1:0];
              r_mem_din  <= pack_pair(r_lhs, in_data);
              r_wr_ptr   <= r_wr_ptr + (ADDR_W+1)'(1);
              r_line_len <= r_line_len + 8'd1;
              // Writing the last usable address closes the line on its own.
              if (in_last || (r_wr_ptr == MEM_LAST_P)) begin
                r_state <= ST_COMMIT;
              end else begin
                r_state <= ST_LHS;
              end
            end
          end
          ST_COMMIT: begin
            r_ptr_we     <= 1'b1;
            r_ptr_line   <= r_line_idx;
            r_ptr_data   <= pack_ptr(r_line_len, 8'(r_line_start));
            r_line_start <= r_wr_ptr[ADDR_W-1:0];
            r_line_len   <= '0;
            r_line_idx   <= r_line_idx + LINE_W'(1);
            r_line_count <= r_line_count + (LINE_W+1)'(1);
            if ((r_wr_ptr > MEM_LAST_P) || (r_line_idx == LINE_LAST)) begin
              r_state <= ST_FULL;
              r_full  <= 1'b1;
            end else begin
              r_state <= ST_LHS;
            end
          end
          ST_FULL: begin
            r_state <= ST_FULL;
          end
          default: begin
            r_state <= ST_LHS;
          end
        endcase
      end
    end
  end

  assign in_ready   = rst_n & w_accept_ok;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_din    = r_mem_din;
  assign ptr_we     = r_ptr_we;
  assign ptr_line   = r_ptr_line;
  assign ptr_data   = r_ptr_data;
  assign line_count = r_line_count;
  assign full       = r_full;
  assign err        = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_transform_loader.sv
// Directed bench for transform_loader: reset, line packing, odd lines, clear,
// memory-full and line-table-full boundaries.
module tb_transform_loader;
  import transforms_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din;
  logic        ptr_we;
  logic [7:0]  ptr_line;
  logic [15:0] ptr_data;
  logic [8:0]  line_count;
  logic        full;
  logic        err;
  state_t      dbg_state;

  int checks   = 0;
  int failures = 0;

  // Observed write logs: {addr, data}.
  logic [23:0] mem_log[$];
  logic [23:0] ptr_log[$];

  transform_loader #(.ADDR_W(8), .LINE_W(8), .MEM_LAST(254)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .ptr_we(ptr_we), .ptr_line(ptr_line), .ptr_data(ptr_data),
    .line_count(line_count), .full(full), .err(err), .dbg_state(dbg_state)
  );

  // Clock / reset-free clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) mem_log.push_back({mem_addr, mem_din});
    if (ptr_we) ptr_log.push_back({ptr_line, ptr_data});
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL handshake_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    mem_log.delete();
    ptr_log.delete();
  endtask

  task automatic check_mem(input string name, input logic [23:0] exp_q[$]);
    checks++;
    if (mem_log.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d writes required %0d", name, mem_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mem_log.size(); i++) begin
      checks++;
      if (mem_log[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s[%0d]: got %h required %h", name, i, mem_log[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_ptr(input string name, input logic [23:0] exp_q[$]);
    checks++;
    if (ptr_log.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d entries required %0d", name, ptr_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ptr_log.size(); i++) begin
      checks++;
      if (ptr_log[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s[%0d]: got %h required %h", name, i, ptr_log[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    idle(3);
    checks++;
    if ({mem_we, ptr_we, full, err, in_ready} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 00000", {mem_we, ptr_we, full, err, in_ready});
    end
    checks++;
    if (line_count !== 9'd0) begin
      failures++;
      $display("FAIL reset_line_count: got %0d required 0", line_count);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after: got %b required 1", in_ready);
    end
    idle(1);
  endtask

  task automatic test_two_lines();
    mem_log.delete(); ptr_log.delete();
    send_byte("1", 0); send_byte("1", 0);
    send_byte("s", 0); send_byte(" ", 0);
    send_byte("1", 0); send_byte("t", 1);
    idle(3);
    check_mem("line0_mem", '{24'h00_3131, 24'h01_7320, 24'h02_3174});
    check_ptr("line0_ptr", '{24'h00_0300});
    checks++;
    if (line_count !== 9'd1) begin
      failures++;
      $display("FAIL line0_count: got %0d required 1", line_count);
    end
    mem_log.delete(); ptr_log.delete();
    send_byte("s", 0); send_byte(" ", 0);
    send_byte("^", 0); send_byte("2", 1);
    idle(3);
    check_mem("line1_mem", '{24'h03_7320, 24'h04_5E32});
    check_ptr("line1_ptr", '{24'h01_0203});
    checks++;
    if (line_count !== 9'd2 || err !== 1'b0) begin
      failures++;
      $display("FAIL line1_count_err: got %0d/%b required 2/0", line_count, err);
    end
  endtask

  task automatic test_reset_mid();
    mem_log.delete(); ptr_log.delete();
    send_byte("x", 0);
    send_byte("y", 0);
    // Write strobe for the pair is live now; reset must kill it.
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, ptr_we} !== 2'b00 || line_count !== 9'd0) begin
      failures++;
      $display("FAIL reset_mid: got we=%b count=%0d required 00/0", {mem_we, ptr_we}, line_count);
    end
    idle(2);
    rst_n = 1'b1;
    idle(4);
    checks++;
    if (mem_log.size() != 0 || ptr_log.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_writes: got %0d/%0d required 0/0", mem_log.size(), ptr_log.size());
    end
  endtask

  task automatic test_odd_line();
    do_reset();
    send_byte("a", 1);
    idle(3);
    check_mem("odd_mem", '{});
    check_ptr("odd_ptr", '{24'h00_0000});
    checks++;
    if (err !== 1'b1 || line_count !== 9'd1) begin
      failures++;
      $display("FAIL odd_err: got err=%b count=%0d required 1/1", err, line_count);
    end
    mem_log.delete(); ptr_log.delete();
    send_byte("b", 0); send_byte("c", 1);
    idle(3);
    check_mem("after_odd_mem", '{24'h00_6263});
    check_ptr("after_odd_ptr", '{24'h01_0100});
  endtask

  task automatic test_clear();
    mem_log.delete(); ptr_log.delete();
    send_byte("q", 0);
    in_valid = 1'b1; in_data = "r"; in_last = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    idle(3);
    checks++;
    if (mem_log.size() != 0 || line_count !== 9'd0 || err !== 1'b1) begin
      failures++;
      $display("FAIL clear_state: got writes=%0d count=%0d err=%b required 0/0/1",
               mem_log.size(), line_count, err);
    end
    send_byte("d", 0); send_byte("e", 1);
    idle(3);
    check_mem("clear_mem", '{24'h00_6465});
    check_ptr("clear_ptr", '{24'h00_0100});
  endtask

  task automatic test_mem_full();
    logic [23:0] last_w;
    do_reset();
    for (int i = 0; i < 255; i++) begin
      send_byte(8'(i), 0);
      send_byte(~8'(i), 0);
    end
    idle(3);
    checks++;
    if (mem_log.size() != 255) begin
      failures++;
      $display("FAIL memfull_count: got %0d required 255", mem_log.size());
    end else begin
      last_w = mem_log[254];
      checks++;
      if (last_w !== {8'd254, 8'd254, 8'd1}) begin
        failures++;
        $display("FAIL memfull_last: got %h required %h", last_w, {8'd254, 8'd254, 8'd1});
      end
    end
    check_ptr("memfull_ptr", '{24'h00_FF00});
    checks++;
    if (full !== 1'b1 || in_ready !== 1'b0 || line_count !== 9'd1) begin
      failures++;
      $display("FAIL memfull_flags: got full=%b rdy=%b count=%0d required 1/0/1",
               full, in_ready, line_count);
    end
    clear = 1'b1;
    idle(2);
    clear = 1'b0;
    checks++;
    if (full !== 1'b1 || line_count !== 9'd1) begin
      failures++;
      $display("FAIL full_clear_ignored: got full=%b count=%0d required 1/1", full, line_count);
    end
  endtask

  task automatic test_table_full();
    do_reset();
    for (int i = 0; i < 255; i++) send_byte("z", 1);
    idle(3);
    checks++;
    if (full !== 1'b0 || line_count !== 9'd255) begin
      failures++;
      $display("FAIL table_pre: got full=%b count=%0d required 0/255", full, line_count);
    end
    send_byte("z", 1);
    idle(3);
    checks++;
    if (full !== 1'b1 || in_ready !== 1'b0 || line_count !== 9'd256) begin
      failures++;
      $display("FAIL table_full: got full=%b rdy=%b count=%0d required 1/0/256",
               full, in_ready, line_count);
    end
    checks++;
    if (ptr_log.size() != 256 || ptr_log[ptr_log.size()-1] !== 24'hFF_0000) begin
      failures++;
      $display("FAIL table_last_ptr: got n=%0d required 256 ending ff0000", ptr_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_two_lines();
    test_reset_mid();
    test_odd_line();
    test_clear();
    test_mem_full();
    test_table_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
